button_reader: RTL

Input-side counterpart to the LED output blocks: it reads the board push-buttons that the user presses.
- Synchronizes and debounces NUM_BTN raw button inputs.
- Classifies each press as short or long.
- Emits single-cycle event pulses that downstream logic (runner speed/direction control, mode select) consumes.
- Sits between the top-level button pins and the control logic, in the same clock domain as the LED drivers.

---
 rtl/button_pkg.sv | 22 ++
 rtl/button_channel.sv | 169 ++++++++++++++++
 rtl/button_reader.sv | 42 ++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button reader: channel state encoding and
// the counter-width helper used by every channel.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    LONG_HELD = 3'd3,
    DEB_REL   = 3'd4
  } btn_state_t;

  // Width that holds the largest cycle count, plus one spare bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-FF synchronizer, debounce/hold FSM and pulse outputs.
// Auto-repeat is built only when BUTTON_READER_AUTOREPEAT_EN is defined.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000,
  parameter int REPEAT_CYCLES   = 4500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic          REL_LEVEL = (ACTIVE_LOW != 0);

  logic [1:0]    sync_reg;
  logic          s;
  btn_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic          was_long_reg, was_long_next;
  logic          pressed_reg, pressed_next;
  logic          press_reg, press_next;
  logic          release_reg, release_next;
  logic          short_reg, short_next;
  logic          long_reg, long_next;

  assign s       = (ACTIVE_LOW != 0) ? ~sync_reg[1] : sync_reg[1];
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_ONE;

`ifdef BUTTON_READER_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  logic repeat_reg, repeat_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg     <= {2{REL_LEVEL}};
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      was_long_reg <= 1'b0;
      pressed_reg  <= 1'b0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      short_reg    <= 1'b0;
      long_reg     <= 1'b0;
`ifdef BUTTON_READER_AUTOREPEAT_EN
      repeat_reg   <= 1'b0;
`endif
    end else begin
      sync_reg     <= {sync_reg[0], btn_raw};
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      was_long_reg <= was_long_next;
      pressed_reg  <= pressed_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
      short_reg    <= short_next;
      long_reg     <= long_next;
`ifdef BUTTON_READER_AUTOREPEAT_EN
      repeat_reg   <= repeat_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    was_long_next = was_long_reg;
    press_next    = 1'b0;
    release_next  = 1'b0;
    short_next    = 1'b0;
    long_next     = 1'b0;
`ifdef BUTTON_READER_AUTOREPEAT_EN
    repeat_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        was_long_next = 1'b0;
        if (s) begin
          state_next = DEB_PRESS;
          cnt_next   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = HELD;
          press_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HELD: begin
        if (!s) begin
          state_next = DEB_REL;
          cnt_next   = '0;
        end else if (cnt_reg == LONG_LAST) begin
          state_next    = LONG_HELD;
          long_next     = 1'b1;
          was_long_next = 1'b1;
          cnt_next      = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      LONG_HELD: begin
        if (!s) begin
          state_next = DEB_REL;
          cnt_next   = '0;
        end
`ifdef BUTTON_READER_AUTOREPEAT_EN
        else if (cnt_reg == REP_LAST) begin
          repeat_next = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_inc;
        end
`endif
      end
      DEB_REL: begin
        // A bounce back to pressed resumes the hold with a fresh count.
        if (s) begin
          state_next = was_long_reg ? LONG_HELD : HELD;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
          short_next   = ~was_long_reg;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    pressed_next = (state_next == HELD) || (state_next == LONG_HELD) ||
                   (state_next == DEB_REL);
  end

  assign pressed       = pressed_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign short_pulse   = short_reg;
  assign long_pulse    = long_reg;
`ifdef BUTTON_READER_AUTOREPEAT_EN
  assign repeat_pulse  = repeat_reg;
`else
  assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// Board push-button reader: NUM_BTN independent debounced channels with
// press/release/short/long event pulses (auto-repeat via BUTTON_READER_AUTOREPEAT_EN).
module button_reader
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000,
  parameter int REPEAT_CYCLES   = 4500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] short_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_raw[gi]),
      .pressed      (pressed[gi]),
      .press_pulse  (press_pulse[gi]),
      .release_pulse(release_pulse[gi]),
      .short_pulse  (short_pulse[gi]),
      .long_pulse   (long_pulse[gi]),
      .repeat_pulse (repeat_pulse[gi])
    );
  end

endmodule
